// File: rtl/mem_port_sched_pkg.sv
// Shared types and constants for the unified-memory port scheduler.
package mem_port_sched_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   // Scheduler states: idle, or owning the memory on behalf of one requester.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_e;

   // Requester identifiers.
   typedef logic req_id_t;
   localparam req_id_t REQ_IF  = 1'b0;
   localparam req_id_t REQ_MEM = 1'b1;

endpackage

// File: rtl/mem_port_watchdog.sv
// Busy-cycle counter for the scheduler: clears when an access starts,
// counts busy cycles without completion, flags when MAX_WAIT is reached.
module mem_port_watchdog #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic limit_c
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign limit_c = (cnt_q == CNT_W'(MAX_WAIT));

   // Next count: clear wins, otherwise count up and saturate at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !limit_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler shared by instruction fetch and load/store.
// Grants one requester at a time, drives a req/ack memory handshake,
// returns read data, raises pipeline stalls and aborts hung accesses.
// Optional macro ARB_RR_EN: round-robin arbitration instead of MEM-over-IF.
module mem_port_sched
   import mem_port_sched_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_ack,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);

   state_e            state_q, state_d;
   logic              ram_req_q, ram_req_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              mem_valid_q, mem_valid_d;
   logic              err_q, err_d;

   logic              mem_pend_c;
   logic              can_grant_c;
   logic              pick_mem_c;
   logic              grant_mem_c;
   logic              grant_if_c;
   logic              busy_c;
   logic              done_c;
   logic              abort_c;
   req_id_t           busy_id_c;
   logic [DATA_W-1:0] done_data_c;
   logic              wd_clr_c;
   logic              wd_en_c;
   logic              wd_limit_c;

`ifdef ARB_RR_EN
   req_id_t           last_grant_q, last_grant_d;
`endif

   assign ram_req   = ram_req_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_valid = mem_valid_q;
   assign err       = err_q;

   // Stalls are combinational so each pipeline register captures on the
   // edge that ends its completion pulse.
   assign stall_mem = mem_pend_c & ~mem_valid_q;
   assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

   // Arbitration: grants only from IDLE and never while a completion pulse
   // is out, so a request whose stall is releasing is not re-issued.
   always_comb begin
      mem_pend_c  = mem_rd | mem_wr;
      can_grant_c = (state_q == IDLE) && !if_valid_q && !mem_valid_q;
`ifdef ARB_RR_EN
      pick_mem_c  = mem_pend_c && !(if_req && (last_grant_q == REQ_MEM));
`else
      pick_mem_c  = mem_pend_c;
`endif
      grant_mem_c = can_grant_c & pick_mem_c;
      grant_if_c  = can_grant_c & if_req & ~pick_mem_c;
   end

   // Completion decode: ack beats watchdog abort; stores and aborts return 0.
   always_comb begin
      busy_c      = (state_q != IDLE);
      busy_id_c   = (state_q == MEM_BUSY) ? REQ_MEM : REQ_IF;
      done_c      = busy_c & ram_ack;
      abort_c     = busy_c & ~ram_ack & wd_limit_c;
      wd_en_c     = busy_c & ~ram_ack;
      wd_clr_c    = grant_mem_c | grant_if_c;
      done_data_c = ram_rdata;
      if (abort_c || ((busy_id_c == REQ_MEM) && ram_we_q)) begin
         done_data_c = '0;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      ram_req_d   = ram_req_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (grant_mem_c) begin
               state_d     = MEM_BUSY;
               ram_req_d   = 1'b1;
               ram_we_d    = mem_wr;
               ram_addr_d  = mem_addr;
               ram_wdata_d = mem_wdata;
            end else if (grant_if_c) begin
               state_d     = IF_BUSY;
               ram_req_d   = 1'b1;
               ram_we_d    = 1'b0;
               ram_addr_d  = if_addr;
               ram_wdata_d = '0;
            end
         end
         IF_BUSY, MEM_BUSY: begin
            if (done_c || abort_c) begin
               state_d   = IDLE;
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               err_d     = err_q | abort_c;
               if (busy_id_c == REQ_IF) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = done_data_c;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_rdata_d = done_data_c;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            ram_req_d = 1'b0;
            ram_we_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         err_q       <= err_d;
      end
   end

`ifdef ARB_RR_EN
   // Remember the most recent grant so contention alternates.
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_mem_c) begin
         last_grant_d = REQ_MEM;
      end else if (grant_if_c) begin
         last_grant_d = REQ_IF;
      end
   end

   // Last-grant register; reset favours IF as the previous winner.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant_q <= REQ_IF;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Busy-cycle watchdog.
   mem_port_watchdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr_c),
      .en      (wd_en_c),
      .limit_c (wd_limit_c)
   );

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched with a transaction-level reference model.
module tb_mem_port_sched;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 15;
`ifdef ARB_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          ram_req;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_ack;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic [DW-1:0] mem_rdata;
   logic          mem_valid;
   logic          stall_if;
   logic          stall_mem;
   logic          err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   mem_port_sched #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_WAIT (MW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .ram_req   (ram_req),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_ack   (ram_ack),
      .ram_rdata (ram_rdata),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .err       (err)
   );

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference model: who owns the port (0 none, 1 fetch, 2 load/store),
   // how many busy cycles have elapsed, and the expected output values.
   int            m_cur = 0;
   int            m_age = 0;
   logic          m_req = 1'b0;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_ifd = '0;
   logic [DW-1:0] m_memd = '0;
   logic          m_ifv = 1'b0;
   logic          m_memv = 1'b0;
   logic          m_err = 1'b0;
   logic          m_last_mem = 1'b0;
   logic          pv_if, pv_mem, take_mem;
   logic [DW-1:0] res;

   always @(posedge clk) begin
      if (!rst) begin
         m_cur = 0; m_age = 0; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
         m_ifd = '0; m_memd = '0; m_ifv = 0; m_memv = 0; m_err = 0; m_last_mem = 0;
      end else begin
         pv_if  = m_ifv;
         pv_mem = m_memv;
         m_ifv  = 0;
         m_memv = 0;
         if (m_cur == 0) begin
            if (!pv_if && !pv_mem) begin
               take_mem = (mem_rd | mem_wr) && !(RR_ON && if_req && m_last_mem);
               if (take_mem) begin
                  m_cur = 2; m_age = 1; m_req = 1; m_we = mem_wr;
                  m_addr = mem_addr; m_wdata = mem_wdata; m_last_mem = 1;
               end else if (if_req) begin
                  m_cur = 1; m_age = 1; m_req = 1; m_we = 0;
                  m_addr = if_addr; m_wdata = '0; m_last_mem = 0;
               end
            end
         end else if (ram_ack || m_age > int'(MW)) begin
            res = ram_ack ? ram_rdata : '0;
            if (ram_ack && m_cur == 2 && m_we) res = '0;
            if (!ram_ack) m_err = 1;
            if (m_cur == 1) begin m_ifv = 1; m_ifd = res; end
            else begin m_memv = 1; m_memd = res; end
            m_req = 0;
            m_cur = 0;
         end else begin
            m_age++;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk1("ram_req", ram_req, m_req);
         if (m_req) begin
            chk1("ram_we", ram_we, m_we);
            chk32("ram_addr", ram_addr, m_addr);
            chk32("ram_wdata", ram_wdata, m_wdata);
         end
         chk1("if_valid", if_valid, m_ifv);
         chk32("if_rdata", if_rdata, m_ifd);
         chk1("mem_valid", mem_valid, m_memv);
         chk32("mem_rdata", mem_rdata, m_memd);
         chk1("err", err, m_err);
         chk1("stall_mem", stall_mem, (mem_rd | mem_wr) & ~m_memv);
         chk1("stall_if", stall_if, (if_req & ~m_ifv) | ((mem_rd | mem_wr) & ~m_memv));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a request, then ack it in busy cycle n with data d.
   task automatic serve(input int n, input logic [31:0] d);
      int guard = 0;
      while (ram_req !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      chk1("serve_req_seen", ram_req, 1'b1);
      if (ram_req === 1'b1) begin
         for (int i = 1; i < n; i++) tick();
         ram_ack   = 1'b1;
         ram_rdata = d;
         tick();
         ram_ack   = 1'b0;
         ram_rdata = '0;
      end
   endtask

   initial begin
      rst = 0; if_req = 1; if_addr = 32'h0000_0040;
      mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0;
      ram_ack = 0; ram_rdata = '0;

      // Reset hold with a pending fetch.
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp_en = 1'b1;
         chk1("rst_ram_req", ram_req, 1'b0);
         chk1("rst_if_valid", if_valid, 1'b0);
         chk1("rst_mem_valid", mem_valid, 1'b0);
         chk1("rst_err", err, 1'b0);
         chk32("rst_ram_addr", ram_addr, 32'h0);
         chk32("rst_if_rdata", if_rdata, 32'h0);
      end
      rst = 1; if_req = 0;
      tick();

      // Fetch acked in busy cycle 1.
      if_req = 1; if_addr = 32'h0000_0040;
      #1 chk1("fetch_c0_stall_if", stall_if, 1'b1);
      tick();
      chk1("fetch_c1_req", ram_req, 1'b1);
      chk32("fetch_c1_addr", ram_addr, 32'h0000_0040);
      chk1("fetch_c1_we", ram_we, 1'b0);
      chk1("fetch_c1_stall_if", stall_if, 1'b1);
      ram_ack = 1; ram_rdata = 32'h2001_0005;
      tick();
      ram_ack = 0; ram_rdata = '0;
      chk1("fetch_c2_req", ram_req, 1'b0);
      chk1("fetch_c2_valid", if_valid, 1'b1);
      chk32("fetch_c2_rdata", if_rdata, 32'h2001_0005);
      chk1("fetch_c2_stall_if", stall_if, 1'b0);
      tick();
      chk1("fetch_c3_no_reissue", ram_req, 1'b0);
      chk1("fetch_c3_valid", if_valid, 1'b0);
      if_req = 0;
      tick();

      // Contention: both raised together.
      if_req = 1; if_addr = 32'h0000_0044; mem_rd = 1; mem_addr = 32'h0000_0100;
      tick();
      chk32("cont_first_addr", ram_addr, 32'h0000_0100);
      chk1("cont_first_we", ram_we, 1'b0);
      chk1("cont_stall_mem", stall_mem, 1'b1);
      ram_ack = 1; ram_rdata = 32'h1111_2222;
      tick();
      ram_ack = 0; ram_rdata = '0;
      chk1("cont_mem_valid", mem_valid, 1'b1);
      chk32("cont_mem_rdata", mem_rdata, 32'h1111_2222);
      chk1("cont_stall_mem_rel", stall_mem, 1'b0);
      chk1("cont_stall_if_held", stall_if, 1'b1);
      mem_addr = 32'h0000_0104;
      tick();
      chk1("cont_gap", ram_req, 1'b0);
      tick();
`ifdef ARB_RR_EN
      chk32("cont_second_addr", ram_addr, 32'h0000_0044);
`else
      chk32("cont_second_addr", ram_addr, 32'h0000_0104);
`endif
      ram_ack = 1; ram_rdata = 32'h3333_4444;
      tick();
      ram_ack = 0; ram_rdata = '0;
`ifdef ARB_RR_EN
      chk1("cont_second_if_valid", if_valid, 1'b1);
      chk32("cont_second_if_rdata", if_rdata, 32'h3333_4444);
      if_req = 0;
`else
      chk1("cont_second_mem_valid", mem_valid, 1'b1);
      chk32("cont_second_mem_rdata", mem_rdata, 32'h3333_4444);
      mem_rd = 0;
`endif
      tick();
      chk1("cont_gap2", ram_req, 1'b0);
      tick();
`ifdef ARB_RR_EN
      chk32("cont_third_addr", ram_addr, 32'h0000_0104);
`else
      chk32("cont_third_addr", ram_addr, 32'h0000_0044);
`endif
      serve(1, 32'h5555_6666);
      if_req = 0; mem_rd = 0;
      tick();

      // Store acked in busy cycle 4; inputs wiggle while busy.
      mem_wr = 1; mem_addr = 32'h0000_0200; mem_wdata = 32'hDEAD_BEEF;
      tick();
      mem_addr = 32'h0000_0999; mem_wdata = 32'h0123_4567;
      for (int i = 1; i <= 4; i++) begin
         chk1("store_we", ram_we, 1'b1);
         chk32("store_addr", ram_addr, 32'h0000_0200);
         chk32("store_wdata", ram_wdata, 32'hDEAD_BEEF);
         if (i == 4) begin ram_ack = 1; ram_rdata = 32'hFFFF_FFFF; end
         tick();
      end
      ram_ack = 0; ram_rdata = '0;
      chk1("store_valid", mem_valid, 1'b1);
      chk32("store_rdata", mem_rdata, 32'h0);
      mem_wr = 0;
      tick();
      chk1("store_valid_once", mem_valid, 1'b0);

      // Load and store asserted together behave as a store.
      mem_rd = 1; mem_wr = 1; mem_addr = 32'h0000_0210; mem_wdata = 32'h0BAD_F00D;
      tick();
      chk1("rdwr_we", ram_we, 1'b1);
      serve(2, 32'h7777_7777);
      chk32("rdwr_rdata", mem_rdata, 32'h0);
      mem_rd = 0; mem_wr = 0;
      tick();

      // Plain load so a later abort visibly zeroes mem_rdata.
      mem_rd = 1; mem_addr = 32'h0000_0180;
      serve(3, 32'hA5A5_0001);
      chk32("load_rdata", mem_rdata, 32'hA5A5_0001);
      mem_rd = 0;
      tick();

      // Ack in the very cycle the watchdog limit is reached wins.
      mem_rd = 1; mem_addr = 32'h0000_0190;
      serve(int'(MW) + 1, 32'hC0FF_EE01);
      chk1("edge_valid", mem_valid, 1'b1);
      chk32("edge_rdata", mem_rdata, 32'hC0FF_EE01);
      chk1("edge_no_err", err, 1'b0);
      mem_rd = 0;
      tick();

      // Watchdog abort: no ack at all.
      mem_rd = 1; mem_addr = 32'h0000_0300;
      tick();
      for (int i = 1; i <= int'(MW) + 1; i++) begin
         chk1("wd_busy_req", ram_req, 1'b1);
         chk1("wd_busy_err", err, 1'b0);
         tick();
      end
      chk1("wd_abort_req", ram_req, 1'b0);
      chk1("wd_abort_valid", mem_valid, 1'b1);
      chk32("wd_abort_rdata", mem_rdata, 32'h0);
      chk1("wd_abort_err", err, 1'b1);
      mem_rd = 0;
      tick();
      chk1("wd_err_sticky", err, 1'b1);

      // Normal fetch after the abort.
      if_req = 1; if_addr = 32'h0000_0048;
      serve(2, 32'h0000_0013);
      chk1("post_wd_if_valid", if_valid, 1'b1);
      chk32("post_wd_if_rdata", if_rdata, 32'h0000_0013);
      chk1("post_wd_err", err, 1'b1);
      if_req = 0;
      tick();

      // Reset in the second busy cycle; late ack must be ignored.
      if_req = 1; if_addr = 32'h0000_004C;
      tick();
      tick();
      chk1("mid_rst_busy", ram_req, 1'b1);
      rst = 0;
      tick();
      rst = 1; if_req = 0; ram_ack = 1; ram_rdata = 32'hBAD0_BAD0;
      chk1("mid_rst_req_drop", ram_req, 1'b0);
      chk1("mid_rst_err_clr", err, 1'b0);
      tick();
      ram_ack = 0; ram_rdata = '0;
      chk1("mid_rst_no_valid", if_valid, 1'b0);
      chk1("mid_rst_idle", ram_req, 1'b0);
      chk32("mid_rst_rdata", if_rdata, 32'h0);
      tick();
      chk1("mid_rst_no_valid2", if_valid, 1'b0);

      // Scheduler is idle and accepts new work.
      if_req = 1; if_addr = 32'h0000_0050;
      serve(1, 32'h1234_5678);
      chk32("final_if_rdata", if_rdata, 32'h1234_5678);
      if_req = 0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Schedules a single-ported unified memory shared by the IF stage (instruction fetch) and the MEM stage (load/store driven by the EX/MEM pipeline register outputs).
- Grants one requester at a time and drives a req/ack memory handshake.
- Returns read data to the granted requester.
- Generates stall signals that freeze the PC/IF-ID and EX/MEM registers until each access completes.
- Watchdog aborts hung accesses so the pipeline cannot deadlock.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 15, busy cycles without ram_ack before the access is aborted (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-low.
- if_req  in  1  IF stage requests an instruction fetch.
- if_addr  in  ADDR_W  fetch address (PC).
- mem_rd  in  1  load request (EX/MEM MemRd).
- mem_wr  in  1  store request (EX/MEM MemWr).
- mem_addr  in  ADDR_W  load/store address (EX/MEM ALU result).
- mem_wdata  in  DATA_W  store data (EX/MEM Data).
- ram_req  out  1  memory request; held until ack.
- ram_we  out  1  write enable, valid with ram_req.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_ack  in  1  memory completion, single-cycle pulse.
- ram_rdata  in  DATA_W  read data, valid with ram_ack.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  fetch-complete pulse.
- mem_rdata  out  DATA_W  load data.
- mem_valid  out  1  load/store-complete pulse.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze the EX/MEM register and everything upstream of it.
- err  out  1  sticky watchdog-abort flag.

Behaviour:
- States: IDLE, IF_BUSY, MEM_BUSY.
- Reset (rst==0 at a posedge): state IDLE; all registered outputs 0 (ram_req, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_valid, mem_valid, err); watchdog counter 0.
  - Reset mid-access drops ram_req at that edge.
  - A late ram_ack arriving after reset is ignored.
- Grant (IDLE only): a grant is suppressed in any cycle where if_valid or mem_valid is 1. This prevents re-issuing a request whose stall is just releasing.
  - Default arbitration is fixed priority: MEM beats IF (older instruction).
  - On a grant, at the next edge: latch the address, data and write flag into ram_addr/ram_wdata/ram_we; set ram_req=1; move to the *_BUSY state.
  - IF grants always have ram_we=0.
- mem_rd and mem_wr both high: the access is treated as a write.
- Busy state:
  - ram_req, ram_we, ram_addr and ram_wdata stay stable until ack or abort. Input changes are ignored.
  - On ram_ack, at the next edge: ram_req=0; the corresponding *_valid=1 for exactly one cycle; *_rdata=ram_rdata (0 for a store); return to IDLE.
  - ram_ack seen in IDLE is ignored.
- Latency: request high in cycle 0 -> ram_req high in cycle 1. With ack in cycle k (k≥1), *_valid is high in cycle k+1. Minimum completion latency is 2 cycles.
- Stalls are combinational:
  - stall_mem = (mem_rd|mem_wr) & ~mem_valid.
  - stall_if = (if_req & ~if_valid) | stall_mem.
  - So a pipeline register captures on the edge ending the *_valid cycle.
- Watchdog:
  - The counter clears on entering a busy state and increments each busy cycle without ack.
  - When the counter reaches MAX_WAIT, at the next edge: ram_req=0, err=1 (sticky until reset), *_valid pulses with *_rdata=0, and the state returns to IDLE.
  - An ack arriving in the same cycle as the limit is reached takes precedence: normal completion, no error.
- *_rdata holds its value between completions.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. A one-bit last-grant register (reset 0 = IF) is updated on every grant. When both requesters are pending in IDLE, the one not granted last wins.
- Undefined: fixed MEM-over-IF priority, and no last-grant register exists.

Decomposition:
- Shared package: state enum (IDLE/IF_BUSY/MEM_BUSY), requester ID constants (REQ_IF=0, REQ_MEM=1), default ADDR_W/DATA_W.
- One natural sub-module, mem_port_watchdog: counter with clear/enable inputs and a limit-reached output, parameterised by MAX_WAIT.

Test Plan:
- Reset hold: rst=0 for 3 cycles with if_req=1 -> ram_req=0, all outputs 0, no *_valid.
- Fetch, ack after 1 cycle:
  - Stimulus: if_req=1, if_addr=0x0000_0040; ram_ack in cycle 1 with ram_rdata=0x2001_0005.
  - Response: ram_req high in cycle 1 only; if_valid and if_rdata=0x2001_0005 in cycle 2; stall_if=1 in cycles 0-1, 0 in cycle 2; no second request in cycle 2.
- Contention:
  - Stimulus: if_req and mem_rd (addr 0x100) both raised in cycle 0.
  - Response: MEM granted first (ram_addr=0x100, ram_we=0); IF granted only after mem_valid. With ARB_RR_EN and last grant=MEM, IF is granted first.
- Store:
  - Stimulus: mem_wr=1, addr 0x200, wdata 0xDEAD_BEEF; ack after 4 cycles.
  - Response: ram_we=1 with stable addr/data for 4 cycles; mem_valid one cycle; mem_rdata=0.
- Watchdog: MAX_WAIT=15, mem_rd with no ack -> abort after 15 busy cycles; err=1 and stays 1; mem_valid pulse with mem_rdata=0; next if_req is serviced normally.
- Reset mid-access: rst=0 in the second busy cycle, ack delivered the following cycle -> ram_req=0 after the edge, ack ignored, state IDLE, no *_valid.
